// File: rtl/instr_sequencer_if.sv
// Interface bundle between the sequencer, its instruction ROM and the board display.
// The master modport is the sequencer side; the slave modport is the ROM/display side.
interface instr_sequencer_if;
    logic       start;
    logic       pause;
    logic [7:0] instruction;
    logic [7:0] address;
    logic       rom_clear;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;
    logic [7:0] rw;
    logic       busy;
    logic       halted;
    logic       fault;
    logic [7:0] exec_count;

    modport master (
        input  start, pause, instruction,
        output address, rom_clear, s0, s1, s2, s3, rw, busy, halted, fault, exec_count
    );

    modport slave (
        output start, pause, instruction,
        input  address, rom_clear, s0, s1, s2, s3, rw, busy, halted, fault, exec_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/execute controller: drives the ROM address and executes one instruction per clock
// on four slot registers until HALT or until the last program word has run.
module instr_sequencer #(
    parameter int PROG_DEPTH = 32,
    parameter int DATA_W     = 8
) (
    input  logic                clk,
    input  logic                clear,
    instr_sequencer_if.master   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_SUBI = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;
    localparam logic [7:0] LAST_ADDR = 8'(PROG_DEPTH - 1);

    state_t                  state_r, state_s;
    logic [7:0]              pc_r, pc_s;
    logic [3:0][DATA_W-1:0]  slot_r, slot_s;
    logic [DATA_W-1:0]       rw_r, rw_s;
    logic [7:0]              cnt_r, cnt_s;
    logic                    busy_r, busy_s;
    logic                    halted_r, halted_s;
    logic                    fault_r, fault_s;

    logic [1:0]              op_s, src_s, dst_s;
    logic [DATA_W-1:0]       imm_s, result_s;

    // Instruction field split and ALU result (src read before the edge, so src==dst works).
    always_comb begin
        op_s  = bus.instruction[7:6];
        src_s = bus.instruction[5:4];
        dst_s = bus.instruction[3:2];
        imm_s = {{(DATA_W-2){1'b0}}, bus.instruction[1:0]};
        if (op_s == OP_SUBI) begin
            result_s = slot_r[src_s] - imm_s;
        end else begin
            result_s = slot_r[src_s] + imm_s;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        slot_s   = slot_r;
        rw_s     = rw_r;
        cnt_s    = cnt_r;
        halted_s = halted_r;
        fault_s  = fault_r;
        case (state_r)
            ST_IDLE: begin
                pc_s = 8'd0;
                if (bus.start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.pause) begin
                    state_s = ST_RUN;
                end else if (op_s == OP_HALT) begin
                    state_s  = ST_DONE;
                    halted_s = 1'b1;
                end else begin
                    if (op_s == OP_ADDI || op_s == OP_SUBI) begin
                        slot_s[dst_s] = result_s;
                        rw_s          = result_s;
                    end else begin
                        slot_s = slot_r;
                    end
                    if (cnt_r != 8'hFF) begin
                        cnt_s = cnt_r + 8'd1;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    // Running off the end of program space: keep the address in range.
                    if (pc_r >= LAST_ADDR) begin
                        state_s = ST_DONE;
                        fault_s = 1'b1;
                        pc_s    = LAST_ADDR;
                    end else begin
                        pc_s = pc_r + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = 8'd0;
            end
        endcase
        busy_s = (state_s == ST_RUN);
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r  <= ST_IDLE;
            pc_r     <= 8'd0;
            slot_r   <= '0;
            rw_r     <= '0;
            cnt_r    <= 8'd0;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            slot_r   <= slot_s;
            rw_r     <= rw_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            halted_r <= halted_s;
            fault_r  <= fault_s;
        end
    end

    // Output mapping; rom_clear follows clear without a register so the ROM resets together.
    always_comb begin
        bus.address    = pc_r;
        bus.rom_clear  = clear;
        bus.s0         = 8'(slot_r[0]);
        bus.s1         = 8'(slot_r[1]);
        bus.s2         = 8'(slot_r[2]);
        bus.s3         = 8'(slot_r[3]);
        bus.rw         = 8'(rw_r);
        bus.busy       = busy_r;
        bus.halted     = halted_r;
        bus.fault      = fault_r;
        bus.exec_count = cnt_r;
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a behavioural combinational ROM.
module tb_instr_sequencer;
    logic clk;
    logic clear;
    int   errors;
    int   checks;
    logic [7:0] rom [32];

    instr_sequencer_if ifc ();

    instr_sequencer #(.PROG_DEPTH(32), .DATA_W(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (ifc.address < 8'd32) begin
            ifc.instruction = rom[ifc.address[4:0]];
        end else begin
            ifc.instruction = 8'h00;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag,
                               input logic [7:0] a, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] erw,
                               input logic [7:0] ecnt, input logic eb, input logic eh,
                               input logic ef);
        check({tag, ".address"}, 32'(ifc.address), 32'(a));
        check({tag, ".s0"}, 32'(ifc.s0), 32'(e0));
        check({tag, ".s1"}, 32'(ifc.s1), 32'(e1));
        check({tag, ".s2"}, 32'(ifc.s2), 32'(e2));
        check({tag, ".s3"}, 32'(ifc.s3), 32'(e3));
        check({tag, ".rw"}, 32'(ifc.rw), 32'(erw));
        check({tag, ".exec_count"}, 32'(ifc.exec_count), 32'(ecnt));
        check({tag, ".busy"}, 32'(ifc.busy), 32'(eb));
        check({tag, ".halted"}, 32'(ifc.halted), 32'(eh));
        check({tag, ".fault"}, 32'(ifc.fault), 32'(ef));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic do_start();
        ifc.start = 1'b1;
        tick(1);
        ifc.start = 1'b0;
    endtask

    task automatic load_counter();
        logic [7:0] pat [4];
        pat[0] = 8'h45; pat[1] = 8'h59; pat[2] = 8'h6D; pat[3] = 8'h71;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < 28; i++) rom[i] = pat[i % 4];
        rom[28] = 8'hC3;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        clear     = 1'b1;
        ifc.start = 1'b0;
        ifc.pause = 1'b0;
        load_counter();

        // Reset state and rom_clear forwarding
        tick(1);
        check("rom_clear_high", 32'(ifc.rom_clear), 32'd1);
        clear = 1'b0;
        #1;
        check("rom_clear_low", 32'(ifc.rom_clear), 32'd0);
        check_state("reset", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(2);
        check("idle_hold_addr", 32'(ifc.address), 32'd0);
        check("idle_busy", 32'(ifc.busy), 32'd0);

        // Counter program
        do_start();
        check("run_busy", 32'(ifc.busy), 32'd1);
        check("run_addr0", 32'(ifc.address), 32'd0);
        ifc.start = 1'b1;  // start must be ignored while running
        tick(4);
        ifc.start = 1'b0;
        check_state("cnt4", 8'd4, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 1'b1, 1'b0, 1'b0);
        tick(25);
        check_state("cnt_final", 8'd28, 8'd28, 8'd25, 8'd26, 8'd27, 8'd28, 8'd28,
                    1'b0, 1'b1, 1'b0);
        do_start();
        tick(3);
        check_state("done_frozen", 8'd28, 8'd28, 8'd25, 8'd26, 8'd27, 8'd28, 8'd28,
                    1'b0, 1'b1, 1'b0);

        // Pause after 3 executes
        do_clear();
        do_start();
        tick(3);
        ifc.pause = 1'b1;
        tick(5);
        check_state("paused", 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 1'b1, 1'b0, 1'b0);
        ifc.pause = 1'b0;
        tick(26);
        check_state("pause_final", 8'd28, 8'd28, 8'd25, 8'd26, 8'd27, 8'd28, 8'd28,
                    1'b0, 1'b1, 1'b0);

        // Clear mid-run at address 10, then rerun
        do_clear();
        do_start();
        tick(10);
        check("mid_addr10", 32'(ifc.address), 32'd10);
        do_clear();
        check_state("mid_clear", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        check("mid_clear_idle_addr", 32'(ifc.address), 32'd0);
        do_start();
        tick(29);
        check_state("rerun_final", 8'd28, 8'd28, 8'd25, 8'd26, 8'd27, 8'd28, 8'd28,
                    1'b0, 1'b1, 1'b0);

        // SUBI wrap from zero
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'h81;
        rom[1] = 8'hC3;
        do_clear();
        do_start();
        tick(1);
        check("subi_s0_early", 32'(ifc.s0), 32'd255);
        check("subi_busy_early", 32'(ifc.busy), 32'd1);
        tick(1);
        check_state("subi", 8'd1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd1, 1'b0, 1'b1, 1'b0);

        // No HALT: run off the end of program space
        rom[0] = 8'h00;
        rom[1] = 8'h00;
        do_clear();
        do_start();
        tick(31);
        check("nohalt_addr31", 32'(ifc.address), 32'd31);
        check("nohalt_busy31", 32'(ifc.busy), 32'd1);
        check("nohalt_cnt31", 32'(ifc.exec_count), 32'd31);
        tick(1);
        check_state("nohalt", 8'd31, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd32, 1'b0, 1'b0, 1'b1);
        tick(3);
        check("nohalt_hold_addr", 32'(ifc.address), 32'd31);
        check("nohalt_hold_cnt", 32'(ifc.exec_count), 32'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
